// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundles the engine-side handshakes and the SDRAM pad bus
// that the arbiter multiplexes.
//
// Handshake semantics (req/enable): an engine raises *_req while it has work
// and keeps it high until it is done. The arbiter answers with *_enable, which
// stays high for the whole tenure. An engine may only drive a command that
// will reach the pads while its enable is high. It releases the bus by
// showing *_idle=1 with *_req=0. The arbiter then drops enable on the next
// edge. auto_refresh asks the current owner to park. The owner signals that
// it is safe to refresh with *_wait_for_refresh=1 together with *_idle=1.
//
// Modports:
//   slave  - arbiter view: engine signals in, grants/pad bus/flags out
//   master - engine/pad side view: the reverse
interface sdram_arbiter_if;
  logic        wr_req;
  logic        rd_req;
  logic        wr_idle;
  logic        rd_idle;
  logic        wr_wait_for_refresh;
  logic        rd_wait_for_refresh;
  logic        wr_enable;
  logic        rd_enable;
  logic        auto_refresh;
  logic [2:0]  wr_command;
  logic [2:0]  rd_command;
  logic [11:0] wr_address;
  logic [11:0] rd_address;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic [2:0]  sd_command;
  logic [11:0] sd_address;
  logic [1:0]  sd_bank;
  logic [15:0] sd_data;
  logic [1:0]  sd_mask;
  logic        refresh_overrun;

  modport slave (
    input  wr_req, rd_req, wr_idle, rd_idle,
    input  wr_wait_for_refresh, rd_wait_for_refresh,
    input  wr_command, rd_command, wr_address, rd_address,
    input  wr_bank, rd_bank, wr_data, wr_mask,
    output wr_enable, rd_enable, auto_refresh,
    output sd_command, sd_address, sd_bank, sd_data, sd_mask,
    output refresh_overrun
  );

  modport master (
    output wr_req, rd_req, wr_idle, rd_idle,
    output wr_wait_for_refresh, rd_wait_for_refresh,
    output wr_command, rd_command, wr_address, rd_address,
    output wr_bank, rd_bank, wr_data, wr_mask,
    input  wr_enable, rd_enable, auto_refresh,
    input  sd_command, sd_address, sd_bank, sd_data, sd_mask,
    input  refresh_overrun
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the single SDRAM command/address/data bus and shares it
// between the write engine and the read engine. It also schedules the
// periodic AUTO REFRESH command.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous reset, active-low
//   bus        - sdram_arbiter_if.slave: engine req/idle/wait_for_refresh and
//                command inputs, wr/rd_enable grants, auto_refresh,
//                sd_* pad bus, sticky refresh_overrun flag
//   dbg_state  - current FSM state (0 IDLE, 1 GRANT_WR, 2 GRANT_RD,
//                3 REF_CMD, 4 REF_WAIT)
//
// All outputs are registered. sd_* carry the owner's inputs with exactly one
// cycle of latency. Outside a grant the bus shows NOP with all fields zero.
`ifndef SDRAM_CMD_NOP
`define SDRAM_CMD_NOP 3'b111
`endif
`ifndef SDRAM_CMD_AR
`define SDRAM_CMD_AR 3'b001
`endif

module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 1560,
  parameter int T_RFC            = 7
) (
  input  logic             clk,
  input  logic             rst,
  sdram_arbiter_if.slave   bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT_WR = 3'd1,
    GRANT_RD = 3'd2,
    REF_CMD  = 3'd3,
    REF_WAIT = 3'd4
  } state_t;

  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int DW = (T_RFC > 1) ? $clog2(T_RFC) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);
  // The delay counts T_RFC-1 down to 0, which gives exactly T_RFC NOP cycles
  // in REF_WAIT.
  localparam logic [DW-1:0] DELAY_LOAD = DW'(T_RFC - 1);

  state_t      state;
  logic        last_grant_rd;  // 1: the read engine held the bus last
  logic        regrant_ok;     // the refresh interrupted a grant, so resume it
  logic [TW-1:0] timer;
  logic [DW-1:0] delay;
  logic        pending;
  logic        overrun;
  logic        wr_en_q;
  logic        rd_en_q;
  logic [2:0]  cmd_q;
  logic [11:0] addr_q;
  logic [1:0]  bank_q;
  logic [15:0] data_q;
  logic [1:0]  mask_q;

  logic timer_hit;
  assign timer_hit = (timer == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant_rd <= 1'b1;
      regrant_ok    <= 1'b0;
      timer         <= TIMER_RELOAD;
      delay         <= '0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      cmd_q         <= `SDRAM_CMD_NOP;
      addr_q        <= '0;
      bank_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
    end else begin
      // Refresh timer. A new expiry always sets pending, even on the cycle
      // REF_CMD retires the previous request. An expiry while a request is
      // still waiting is an overrun; it never queues a second refresh.
      if (timer_hit) begin
        timer   <= TIMER_RELOAD;
        pending <= 1'b1;
        if (pending && (state != REF_CMD)) overrun <= 1'b1;
      end else begin
        timer <= timer - TW'(1);
        if (state == REF_CMD) pending <= 1'b0;
      end

      // Bus defaults: idle NOP, no grant. The branches below override them.
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      cmd_q   <= `SDRAM_CMD_NOP;
      addr_q  <= '0;
      bank_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;

      case (state)
        IDLE: begin
          if (pending) begin
            state      <= REF_CMD;
            cmd_q      <= `SDRAM_CMD_AR;
            regrant_ok <= 1'b0;
          end else if (bus.wr_req && (!bus.rd_req || last_grant_rd)) begin
            state <= GRANT_WR;
          end else if (bus.rd_req) begin
            state <= GRANT_RD;
          end
        end

        GRANT_WR: begin
          if (pending && bus.wr_wait_for_refresh && bus.wr_idle) begin
            state         <= REF_CMD;
            cmd_q         <= `SDRAM_CMD_AR;
            last_grant_rd <= 1'b0;
            regrant_ok    <= 1'b1;
          end else if (bus.wr_idle && !bus.wr_req) begin
            state         <= IDLE;
            last_grant_rd <= 1'b0;
          end else begin
            wr_en_q <= 1'b1;
            cmd_q   <= bus.wr_command;
            addr_q  <= bus.wr_address;
            bank_q  <= bus.wr_bank;
            data_q  <= bus.wr_data;
            mask_q  <= bus.wr_mask;
          end
        end

        GRANT_RD: begin
          if (pending && bus.rd_wait_for_refresh && bus.rd_idle) begin
            state         <= REF_CMD;
            cmd_q         <= `SDRAM_CMD_AR;
            last_grant_rd <= 1'b1;
            regrant_ok    <= 1'b1;
          end else if (bus.rd_idle && !bus.rd_req) begin
            state         <= IDLE;
            last_grant_rd <= 1'b1;
          end else begin
            rd_en_q <= 1'b1;
            cmd_q   <= bus.rd_command;
            addr_q  <= bus.rd_address;
            bank_q  <= bus.rd_bank;
          end
        end

        REF_CMD: begin
          state <= REF_WAIT;
          delay <= DELAY_LOAD;
        end

        REF_WAIT: begin
          if (delay != '0) begin
            delay <= delay - DW'(1);
          end else if (regrant_ok && last_grant_rd && bus.rd_req) begin
            state <= GRANT_RD;
          end else if (regrant_ok && !last_grant_rd && bus.wr_req) begin
            state <= GRANT_WR;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_enable       = wr_en_q;
  assign bus.rd_enable       = rd_en_q;
  assign bus.auto_refresh    = pending;
  assign bus.refresh_overrun = overrun;
  assign bus.sd_command      = cmd_q;
  assign bus.sd_address      = addr_q;
  assign bus.sd_bank         = bank_q;
  assign bus.sd_data         = data_q;
  assign bus.sd_mask         = mask_q;
  assign dbg_state           = state;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Owns the single SDRAM command/address/data bus and shares it between the write engine (sdram_write) and the read engine (sdram_read).
- Schedules periodic AUTO REFRESH: raises auto_refresh to the active engine, waits for it to park, then issues the refresh itself.
- Sits between the engines and the SDRAM pad registers inside the wb_sdram controller.

Parameters:
- REFRESH_INTERVAL, 1560: clock cycles between refresh requests (7.8 us at 200 MHz).
- T_RFC, 7: NOP cycles held after an AUTO REFRESH command before the bus is re-granted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- wr_req  in  1  write engine has work (fifo_ready or enable)
- rd_req  in  1  read engine has work
- wr_idle, rd_idle  in  1 each  engine parked, delay==0
- wr_wait_for_refresh, rd_wait_for_refresh  in  1 each  engine safe to refresh
- wr_enable, rd_enable  out  1 each  bus grant to engine
- auto_refresh  out  1  refresh pending, to both engines
- wr_command, rd_command  in  3 each  engine command
- wr_address, rd_address  in  12 each
- wr_bank, rd_bank  in  2 each
- wr_data, wr_mask  in  16 / 2  write data and mask
- sd_command  out  3  to SDRAM pads
- sd_address  out  12
- sd_bank  out  2
- sd_data  out  16
- sd_mask  out  2
- refresh_overrun  out  1  sticky flag: timer expired while a refresh was still pending

Behaviour:
- Reset (rst==0 at posedge):
  - sd_command = `SDRAM_CMD_NOP; sd_address, sd_bank, sd_data, sd_mask = 0.
  - wr_enable = rd_enable = auto_refresh = refresh_overrun = 0.
  - state = IDLE; last_grant = RD, so the first tie goes to WR.
  - Timer loaded with REFRESH_INTERVAL-1.
  - Reset mid-grant or mid-refresh drops to this state on the same edge; no command is completed.
- Refresh timer:
  - Free-running down-counter; at 0 it reloads REFRESH_INTERVAL-1 and sets pending.
  - auto_refresh = pending, registered.
  - If the timer hits 0 while pending is already 1, refresh_overrun is set (sticky until reset) and pending stays 1; there is no double refresh.
- States:
  - IDLE:
    - If pending, go to REF_CMD.
    - Else if exactly one of wr_req/rd_req, grant it.
    - Else if both, grant opposite of last_grant.
    - Enable is asserted the cycle after the decision; the bus shows NOP while in IDLE.
  - GRANT_WR / GRANT_RD:
    - Enable held high; sd_* <= owner's command/address/bank (and wr_data/wr_mask in GRANT_WR, 0 in GRANT_RD) each cycle.
    - Mux latency is exactly 1 cycle, identical for all fields.
    - If pending and the owner's wait_for_refresh==1 and owner idle==1: drop enable, record last_grant, go to REF_CMD.
    - Else if owner idle==1 and owner req==0: drop enable, record last_grant, go to IDLE.
  - REF_CMD: sd_command = `SDRAM_CMD_AR for one cycle, address/bank 0; clear pending; load delay T_RFC; go to REF_WAIT.
  - REF_WAIT:
    - NOP until delay==0.
    - Then, if the previous owner's req is still 1, re-grant it; else go to IDLE.
    - This restores the interrupted engine without a fairness switch.
- Both enables are never high in the same cycle.
- Only the granted engine drives sd_*; the other engine's inputs are ignored.
- If pending rises in the same cycle a request arrives in IDLE, refresh wins.
- The owner holding wait_for_refresh low blocks refresh indefinitely; the overrun flag exposes this.

Test Plan:
- Reset hold, then rst=1 with no requests: sd_command=NOP every cycle; auto_refresh rises at cycle REFRESH_INTERVAL; AR issued 1 cycle later; 7 NOPs follow; auto_refresh falls.
- wr_req=1 only: wr_enable=1 two cycles after the request; wr_command=ACT with wr_address=0x123 appears on sd_command/sd_address one cycle later; wr_req=0 with wr_idle=1 -> wr_enable=0 next cycle.
- wr_req=rd_req=1 in IDLE after reset: WR is granted; after WR releases while rd_req is still 1, RD is granted; next tie goes to WR.
- Refresh during a write: owner asserts wr_wait_for_refresh=1 and wr_idle=1 with auto_refresh=1 -> wr_enable=0, one AR, T_RFC NOPs, then wr_enable=1 again because wr_req is held.
- Owner holds wait_for_refresh=0 past a second timer expiry -> refresh_overrun=1 and stays 1 until rst=0.
- rst=0 during REF_WAIT or GRANT_RD: on the next edge every output is at its reset value and the timer is reloaded.
